xif_offload_master: RTL and testbench

Core-side initiator for the CV-X-IF coprocessor protocol: takes one offload request at a time from the core's execute stage, drives the issue, commit and result transactions against a coprocessor such as the AES unit, and returns a register writeback plus a completion status. It sits between the core pipeline and the coprocessor port. It is used in SoC integration and as the bus-functional driver in coprocessor benches. Only one transaction is in flight at a time.

---
 rtl/xif_offload_master_if.sv | 57 +++++
 rtl/xif_offload_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_xif_offload_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_offload_master_if.sv
// ============================================================================
// Module      : xif_offload_master_if
// Description : Coprocessor-side bundle of the offload master: the issue,
//               commit and result channels. Signal suffixes (_i/_o) are named
//               from the master's point of view.
//               master modport : core-side initiator (xif_offload_master)
//               slave  modport : coprocessor
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface xif_offload_master_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter int unsigned X_RFW_WIDTH = 32
);
    // Issue channel
    logic                     issue_valid_o;
    logic                     issue_ready_i;
    logic [31:0]              issue_instr_o;
    logic [X_ID_WIDTH-1:0]    issue_id_o;
    logic [2*X_RFR_WIDTH-1:0] issue_rs_o;
    logic [1:0]               issue_rs_valid_o;
    logic                     issue_accept_i;
    logic                     issue_writeback_i;

    // Commit channel
    logic                     commit_valid_o;
    logic [X_ID_WIDTH-1:0]    commit_id_o;
    logic                     commit_kill_o;

    // Result channel
    logic                     result_valid_i;
    logic                     result_ready_o;
    logic [X_ID_WIDTH-1:0]    result_id_i;
    logic [4:0]               result_rd_i;
    logic                     result_we_i;
    logic [X_RFW_WIDTH-1:0]   result_data_i;

    modport master (
        output issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
        input  issue_ready_i, issue_accept_i, issue_writeback_i,
        output commit_valid_o, commit_id_o, commit_kill_o,
        output result_ready_o,
        input  result_valid_i, result_id_i, result_rd_i, result_we_i, result_data_i
    );

    modport slave (
        input  issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
        output issue_ready_i, issue_accept_i, issue_writeback_i,
        input  commit_valid_o, commit_id_o, commit_kill_o,
        input  result_ready_o,
        output result_valid_i, result_id_i, result_rd_i, result_we_i, result_data_i
    );
endinterface

`default_nettype wire

// File: rtl/xif_offload_master.sv
// ============================================================================
// Module      : xif_offload_master
// Description : Core-side CV-X-IF initiator. Accepts one offload request at a
//               time, runs issue -> commit -> result against the coprocessor,
//               and returns a register writeback plus a completion status
//               (00 ok, 01 rejected, 10 killed, 11 timeout).
// Ports       : clk_i, rst_ni           clock, async active-low reset
//               req_*                   upstream request from execute stage
//               xif (master modport)    issue / commit / result channels
//               wb_*                    register-file writeback strobe
//               done_valid_o/status_o   one-cycle completion report
//               protocol_err_o          sticky protocol violation flag
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xif_offload_master #(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_RFR_WIDTH    = 32,
    parameter int unsigned X_RFW_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,

    input  wire logic                   req_valid_i,
    output logic                        req_ready_o,
    input  wire logic [31:0]            req_instr_i,
    input  wire logic [X_RFR_WIDTH-1:0] req_rs1_i,
    input  wire logic [X_RFR_WIDTH-1:0] req_rs2_i,
    input  wire logic                   req_kill_i,

    xif_offload_master_if.master        xif,

    output logic                        wb_valid_o,
    output logic [4:0]                  wb_rd_o,
    output logic [X_RFW_WIDTH-1:0]      wb_data_o,

    output logic                        done_valid_o,
    output logic [1:0]                  done_status_o,
    output logic                        protocol_err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last RESULT cycle index: the counter starts at 0 on entry, so leaving
    // when it reads TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_REJECT = 2'b01;
    localparam logic [1:0] ST_KILLED = 2'b10;
    localparam logic [1:0] ST_TMO    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESULT = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [31:0]              instr_q, instr_d;
    logic [2*X_RFR_WIDTH-1:0] rs_q, rs_d;
    logic [X_ID_WIDTH-1:0]    id_q, id_d;
    logic [X_ID_WIDTH-1:0]    id_cnt_q, id_cnt_d;
    logic                     kill_q, kill_d;
    logic                     wb_q, wb_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     issue_valid_q, issue_valid_d;
    logic                     commit_valid_q, commit_valid_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [4:0]               wb_rd_q, wb_rd_d;
    logic [X_RFW_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                     done_valid_q, done_valid_d;
    logic [1:0]               done_status_q, done_status_d;
    logic                     err_q, err_d;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            rs_q           <= '0;
            id_q           <= '0;
            id_cnt_q       <= '0;
            kill_q         <= 1'b0;
            wb_q           <= 1'b0;
            tmo_q          <= '0;
            issue_valid_q  <= 1'b0;
            commit_valid_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            done_valid_q   <= 1'b0;
            done_status_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rs_q           <= rs_d;
            id_q           <= id_d;
            id_cnt_q       <= id_cnt_d;
            kill_q         <= kill_d;
            wb_q           <= wb_d;
            tmo_q          <= tmo_d;
            issue_valid_q  <= issue_valid_d;
            commit_valid_q <= commit_valid_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            done_valid_q   <= done_valid_d;
            done_status_q  <= done_status_d;
            err_q          <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rs_d           = rs_q;
        id_d           = id_q;
        id_cnt_d       = id_cnt_q;
        kill_d         = kill_q;
        wb_d           = wb_q;
        tmo_d          = tmo_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        done_valid_d   = 1'b0;
        done_status_d  = done_status_q;
        err_d          = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    instr_d = req_instr_i;
                    rs_d    = {req_rs2_i, req_rs1_i};
                    id_d    = id_cnt_q;
                    kill_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // A kill here is only recorded; the issue request itself is
                // never withdrawn and the kill is delivered on commit.
                if (req_kill_i) begin
                    kill_d = 1'b1;
                end
                if (xif.issue_ready_i) begin
                    if (!xif.issue_accept_i) begin
                        done_valid_d  = 1'b1;
                        done_status_d = ST_REJECT;
                        id_cnt_d      = id_cnt_q + X_ID_WIDTH'(1);
                        state_d       = S_IDLE;
                    end else begin
                        wb_d    = xif.issue_writeback_i;
                        state_d = S_COMMIT;
                    end
                end
            end

            S_COMMIT: begin
                if (req_kill_i) begin
                    kill_d = 1'b1;
                end
                if (kill_q || req_kill_i) begin
                    done_valid_d  = 1'b1;
                    done_status_d = ST_KILLED;
                    id_cnt_d      = id_cnt_q + X_ID_WIDTH'(1);
                    state_d       = S_IDLE;
                end else begin
                    tmo_d   = '0;
                    state_d = S_RESULT;
                end
            end

            S_RESULT: begin
                if (xif.result_valid_i && (xif.result_id_i == id_q)) begin
                    // Write only when the coprocessor announced a writeback
                    // at issue time; otherwise flag it and drop the write.
                    wb_valid_d    = xif.result_we_i & wb_q;
                    wb_rd_d       = xif.result_rd_i;
                    wb_data_d     = xif.result_data_i;
                    if (xif.result_we_i && !wb_q) begin
                        err_d = 1'b1;
                    end
                    done_valid_d  = 1'b1;
                    done_status_d = ST_OK;
                    id_cnt_d      = id_cnt_q + X_ID_WIDTH'(1);
                    state_d       = S_IDLE;
                end else begin
                    // Foreign ID: the handshake completes but data is dropped.
                    if (xif.result_valid_i) begin
                        err_d = 1'b1;
                    end
                    if (tmo_q == TMO_LAST) begin
                        done_valid_d  = 1'b1;
                        done_status_d = ST_TMO;
                        id_cnt_d      = id_cnt_q + X_ID_WIDTH'(1);
                        state_d       = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are only expected in RESULT; anything else is a violation.
        if ((state_q != S_RESULT) && xif.result_valid_i) begin
            err_d = 1'b1;
        end

        // Channel valids are registered images of the state being entered.
        issue_valid_d  = (state_d == S_ISSUE);
        commit_valid_d = (state_d == S_COMMIT);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready_o          = (state_q == S_IDLE);

    assign xif.issue_valid_o    = issue_valid_q;
    assign xif.issue_instr_o    = instr_q;
    assign xif.issue_id_o       = id_q;
    assign xif.issue_rs_o       = rs_q;
    assign xif.issue_rs_valid_o = {2{issue_valid_q}};

    assign xif.commit_valid_o   = commit_valid_q;
    assign xif.commit_id_o      = id_q;
    // Live kill is folded in so a kill arriving in the commit cycle still lands.
    assign xif.commit_kill_o    = commit_valid_q & (kill_q | req_kill_i);

    assign xif.result_ready_o   = (state_q == S_RESULT);

    assign wb_valid_o           = wb_valid_q;
    assign wb_rd_o              = wb_rd_q;
    assign wb_data_o            = wb_data_q;
    assign done_valid_o         = done_valid_q;
    assign done_status_o        = done_status_q;
    assign protocol_err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_xif_offload_master.sv
// ============================================================================
// Module      : tb_xif_offload_master
// Description : Directed self-checking bench for xif_offload_master. The bench
//               plays the core and the coprocessor; inputs change 1ns after
//               each rising edge and outputs are checked at that same point.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xif_offload_master;

    localparam int unsigned X_ID_WIDTH     = 4;
    localparam int unsigned X_RFR_WIDTH    = 32;
    localparam int unsigned X_RFW_WIDTH    = 32;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [31:0]            req_instr_i;
    logic [X_RFR_WIDTH-1:0] req_rs1_i;
    logic [X_RFR_WIDTH-1:0] req_rs2_i;
    logic                   req_kill_i;
    logic                   wb_valid_o;
    logic [4:0]             wb_rd_o;
    logic [X_RFW_WIDTH-1:0] wb_data_o;
    logic                   done_valid_o;
    logic [1:0]             done_status_o;
    logic                   protocol_err_o;

    int checks = 0;
    int errors = 0;

    xif_offload_master_if #(
        .X_ID_WIDTH (X_ID_WIDTH),
        .X_RFR_WIDTH(X_RFR_WIDTH),
        .X_RFW_WIDTH(X_RFW_WIDTH)
    ) xif ();

    xif_offload_master #(
        .X_ID_WIDTH    (X_ID_WIDTH),
        .X_RFR_WIDTH   (X_RFR_WIDTH),
        .X_RFW_WIDTH   (X_RFW_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_instr_i   (req_instr_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_kill_i    (req_kill_i),
        .xif           (xif.master),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .done_valid_o  (done_valid_o),
        .done_status_o (done_status_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i           = 1'b0;
        req_kill_i            = 1'b0;
        xif.issue_ready_i     = 1'b0;
        xif.issue_accept_i    = 1'b0;
        xif.issue_writeback_i = 1'b0;
        xif.result_valid_i    = 1'b0;
        xif.result_id_i       = '0;
        xif.result_rd_i       = '0;
        xif.result_we_i       = 1'b0;
        xif.result_data_i     = '0;
    endtask

    // Presents a request for one cycle (DUT must be in IDLE).
    task automatic send_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        req_valid_i = 1'b1;
        req_instr_i = instr;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_instr_i = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        idle_inputs();
        #1;
        // ---- reset state ----
        chk("rst_req_ready",   64'(req_ready_o),          64'd1);
        chk("rst_issue_valid", 64'(xif.issue_valid_o),    64'd0);
        chk("rst_rs_valid",    64'(xif.issue_rs_valid_o), 64'd0);
        chk("rst_issue_id",    64'(xif.issue_id_o),       64'd0);
        chk("rst_commit",      64'(xif.commit_valid_o),   64'd0);
        chk("rst_res_ready",   64'(xif.result_ready_o),   64'd0);
        chk("rst_wb_valid",    64'(wb_valid_o),           64'd0);
        chk("rst_done",        64'(done_valid_o),         64'd0);
        chk("rst_status",      64'(done_status_o),        64'd0);
        chk("rst_err",         64'(protocol_err_o),       64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // ---- 1: aes32esi, minimum latency, id 0 ----
        send_req(32'h22C58533, 32'h0, 32'h0);                 // cycle 1
        chk("t1_issue_valid", 64'(xif.issue_valid_o), 64'd1);
        chk("t1_issue_id",    64'(xif.issue_id_o),    64'd0);
        chk("t1_instr",       64'(xif.issue_instr_o), 64'h22C58533);
        chk("t1_rs_valid",    64'(xif.issue_rs_valid_o), 64'd3);
        chk("t1_req_ready",   64'(req_ready_o),       64'd0);
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1; xif.issue_writeback_i = 1'b1;
        tick();                                               // cycle 2
        idle_inputs();
        chk("t1_commit",      64'(xif.commit_valid_o), 64'd1);
        chk("t1_commit_kill", 64'(xif.commit_kill_o),  64'd0);
        chk("t1_commit_id",   64'(xif.commit_id_o),    64'd0);
        chk("t1_issue_drop",  64'(xif.issue_valid_o),  64'd0);
        tick();                                               // cycle 3
        chk("t1_res_ready",   64'(xif.result_ready_o), 64'd1);
        xif.result_valid_i = 1'b1; xif.result_id_i = 4'd0; xif.result_rd_i = 5'd10;
        xif.result_we_i = 1'b1; xif.result_data_i = 32'h00000063;
        tick();                                               // cycle 4
        idle_inputs();
        chk("t1_wb_valid",    64'(wb_valid_o),    64'd1);
        chk("t1_wb_rd",       64'(wb_rd_o),       64'd10);
        chk("t1_wb_data",     64'(wb_data_o),     64'h63);
        chk("t1_done",        64'(done_valid_o),  64'd1);
        chk("t1_status",      64'(done_status_o), 64'd0);
        chk("t1_req_ready",   64'(req_ready_o),   64'd1);
        chk("t1_err",         64'(protocol_err_o), 64'd0);

        // ---- 2: issue stall for 5 cycles, back-to-back with t1, id 1 ----
        send_req(32'hDEADBEEF, 32'h11111111, 32'h22222222);
        chk("t2_wb_pulse", 64'(wb_valid_o), 64'd0);
        chk("t2_done_pulse", 64'(done_valid_o), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_stall_valid", 64'(xif.issue_valid_o), 64'd1);
            chk("t2_stall_instr", 64'(xif.issue_instr_o), 64'hDEADBEEF);
            chk("t2_stall_id",    64'(xif.issue_id_o),    64'd1);
            chk("t2_stall_rs",    64'(xif.issue_rs_o),    64'h22222222_11111111);
            chk("t2_no_commit",   64'(xif.commit_valid_o), 64'd0);
            if (i == 5) begin
                xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1;
            end
            tick();
        end
        idle_inputs();
        chk("t2_commit", 64'(xif.commit_valid_o), 64'd1);
        tick();
        xif.result_valid_i = 1'b1; xif.result_id_i = 4'd1; xif.result_rd_i = 5'd7;
        xif.result_we_i = 1'b0; xif.result_data_i = 32'h12345678;
        tick();
        idle_inputs();
        chk("t2_no_wb",  64'(wb_valid_o),    64'd0);
        chk("t2_done",   64'(done_valid_o),  64'd1);
        chk("t2_status", 64'(done_status_o), 64'd0);

        // ---- 3: rejected, id 2 ----
        send_req(32'h0000000B, 32'h1, 32'h2);
        chk("t3_issue_id", 64'(xif.issue_id_o), 64'd2);
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b0;
        tick();
        idle_inputs();
        chk("t3_done",      64'(done_valid_o),       64'd1);
        chk("t3_status",    64'(done_status_o),      64'd1);
        chk("t3_no_commit", 64'(xif.commit_valid_o), 64'd0);
        chk("t3_no_wb",     64'(wb_valid_o),         64'd0);

        // ---- 4: kill during ISSUE, id 3 ----
        send_req(32'h0000000B, 32'h3, 32'h4);
        chk("t4_issue_id", 64'(xif.issue_id_o), 64'd3);
        req_kill_i = 1'b1;
        tick();
        req_kill_i = 1'b0;
        chk("t4_valid_kept", 64'(xif.issue_valid_o), 64'd1);
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1;
        tick();
        idle_inputs();
        chk("t4_commit",      64'(xif.commit_valid_o), 64'd1);
        chk("t4_commit_kill", 64'(xif.commit_kill_o),  64'd1);
        chk("t4_commit_id",   64'(xif.commit_id_o),    64'd3);
        chk("t4_res_ready",   64'(xif.result_ready_o), 64'd0);
        tick();
        chk("t4_done",      64'(done_valid_o),       64'd1);
        chk("t4_status",    64'(done_status_o),      64'd2);
        chk("t4_res_ready2", 64'(xif.result_ready_o), 64'd0);

        // ---- 5: wrong result ID then correct one, id 4 ----
        send_req(32'h0000000B, 32'h5, 32'h6);
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1; xif.issue_writeback_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        xif.result_valid_i = 1'b1; xif.result_id_i = 4'd5; xif.result_rd_i = 5'd3;
        xif.result_we_i = 1'b1; xif.result_data_i = 32'hBAD0BAD0;
        tick();
        idle_inputs();
        chk("t5_err",        64'(protocol_err_o),     64'd1);
        chk("t5_no_wb",      64'(wb_valid_o),         64'd0);
        chk("t5_no_done",    64'(done_valid_o),       64'd0);
        chk("t5_still_res",  64'(xif.result_ready_o), 64'd1);
        tick();
        tick();
        xif.result_valid_i = 1'b1; xif.result_id_i = 4'd4; xif.result_rd_i = 5'd3;
        xif.result_we_i = 1'b1; xif.result_data_i = 32'h000000AB;
        tick();
        idle_inputs();
        chk("t5_wb_valid", 64'(wb_valid_o),     64'd1);
        chk("t5_wb_rd",    64'(wb_rd_o),        64'd3);
        chk("t5_wb_data",  64'(wb_data_o),      64'hAB);
        chk("t5_status",   64'(done_status_o),  64'd0);
        chk("t5_err_stky", 64'(protocol_err_o), 64'd1);

        // ---- 6: timeout, id 5 ----
        send_req(32'h0000000B, 32'h7, 32'h8);
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1;
        tick();
        idle_inputs();
        tick();                                   // first RESULT cycle
        for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++) begin
            chk("t6_wait_res", 64'(xif.result_ready_o), 64'd1);
            chk("t6_wait_done", 64'(done_valid_o), 64'd0);
            tick();
        end
        chk("t6_last_res", 64'(xif.result_ready_o), 64'd1);
        tick();
        chk("t6_done",   64'(done_valid_o),  64'd1);
        chk("t6_status", 64'(done_status_o), 64'd3);
        chk("t6_idle",   64'(req_ready_o),   64'd1);

        // ---- 7: asynchronous reset mid-transaction ----
        send_req(32'h0000000B, 32'h9, 32'hA);
        chk("t7_issue", 64'(xif.issue_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t7_rst_issue", 64'(xif.issue_valid_o), 64'd0);
        chk("t7_rst_instr", 64'(xif.issue_instr_o), 64'd0);
        chk("t7_rst_ready", 64'(req_ready_o),       64'd1);
        chk("t7_rst_err",   64'(protocol_err_o),    64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t7_no_commit", 64'(xif.commit_valid_o), 64'd0);
        chk("t7_no_done",   64'(done_valid_o),       64'd0);

        // ---- 8: 17 back-to-back rejected transactions, ID wrap ----
        for (int k = 0; k < 17; k++) begin
            send_req(32'h0000000B, 32'(k), 32'h0);
            chk("t8_issue_id", 64'(xif.issue_id_o), 64'(k % 16));
            xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b0;
            tick();
            idle_inputs();
            chk("t8_done", 64'(done_valid_o), 64'd1);
        end

        // ---- 9: stray result outside RESULT ----
        chk("t9_err_before", 64'(protocol_err_o), 64'd0);
        xif.result_valid_i = 1'b1; xif.result_id_i = 4'd1;
        chk("t9_ready_low", 64'(xif.result_ready_o), 64'd0);
        tick();
        idle_inputs();
        chk("t9_err_after", 64'(protocol_err_o), 64'd1);
        chk("t9_no_wb",     64'(wb_valid_o),     64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
